node_info_ctrl: RTL and testbench

Parametrised successor to the per-node information register of the EER-RL sensor node. It decodes accepted packet-type events, records hop distance, cluster-head role and assigned timeslot, and flags low residual energy. It computes the initial Q-value (residual energy / hop count) with a multi-cycle serial divider and a busy/valid handshake. It sits between the packet parser and the routing/learning logic.

---
 rtl/node_info_ctrl_if.sv | 32 +++
 rtl/node_info_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_node_info_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/node_info_ctrl_if.sv
// Packet-parser <-> node-info bus: accepted packet fields in, per-node state and Q-value out.
// The parser side takes the master modport; node_info_ctrl takes the slave modport.
interface node_info_ctrl_if #(
    parameter int WORD_W = 16
);
    logic              en_MNI;
    logic [2:0]        fPktType;
    logic [WORD_W-1:0] energy;
    logic [WORD_W-1:0] destinationID;
    logic [WORD_W-1:0] hops;
    logic [WORD_W-1:0] timeslot;
    logic [WORD_W-1:0] e_threshold;

    logic [WORD_W-1:0] myNodeID;
    logic [WORD_W-1:0] hopsFromSink;
    logic [WORD_W-1:0] myQValue;
    logic [WORD_W-1:0] myTimeslot;
    logic              role;
    logic              low_E;
    logic              busy;
    logic              q_valid;

    modport master (
        output en_MNI, fPktType, energy, destinationID, hops, timeslot, e_threshold,
        input  myNodeID, hopsFromSink, myQValue, myTimeslot, role, low_E, busy, q_valid
    );

    modport slave (
        input  en_MNI, fPktType, energy, destinationID, hops, timeslot, e_threshold,
        output myNodeID, hopsFromSink, myQValue, myTimeslot, role, low_E, busy, q_valid
    );
endinterface

// File: rtl/node_info_ctrl.sv
// Per-node info register: decodes packet events, records hops/role/timeslot/low-energy, computes Q = energy/hops.
// Latency: field updates 1 cycle after accept; Q-value and q_valid WORD_W+1 cycles after an accepted HB.
// Backpressure: busy high while the serial divider runs; strobes seen while busy are dropped. Optional macro NODE_INFO_LOWE_HYST_EN.
module node_info_ctrl #(
    parameter int                 WORD_W  = 16,
    parameter logic [WORD_W-1:0]  NODE_ID = 16'h000C,
    parameter logic [WORD_W-1:0]  HYST    = 16'h0200
) (
    input  logic             clk,
    input  logic             nrst,
    node_info_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_INV  = 3'b010;
    localparam logic [2:0] PKT_CHTS = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;

    localparam int               CNT_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_W - 1);

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [WORD_W-1:0] quo_q,     quo_d;
    logic [WORD_W-1:0] rem_q,     rem_d;
    logic [WORD_W-1:0] dvs_q,     dvs_d;
    logic [WORD_W-1:0] hops_q,    hops_d;
    logic [WORD_W-1:0] qval_q,    qval_d;
    logic [WORD_W-1:0] tslot_q,   tslot_d;
    logic              role_q,    role_d;
    logic              low_e_q,   low_e_d;
    logic              hb_lock_q, hb_lock_d;
    logic              q_vld_q,   q_vld_d;

    logic              accept;
    logic [WORD_W-1:0] hops_eff;
    logic              low_e_eval;
    logic [WORD_W:0]   rem_shift;
    logic [WORD_W:0]   rem_sub;
    logic              step_fits;

    assign accept   = bus.en_MNI && (state_q == ST_IDLE);
    assign hops_eff = (bus.hops == '0) ? WORD_W'(1) : bus.hops;

`ifdef NODE_INFO_LOWE_HYST_EN
    logic [WORD_W:0]   rel_sum;
    logic [WORD_W-1:0] rel_thr;

    // Release point is threshold + margin, clamped so a high threshold cannot wrap to a tiny value.
    assign rel_sum = {1'b0, bus.e_threshold} + {1'b0, HYST};
    assign rel_thr = rel_sum[WORD_W] ? '1 : rel_sum[WORD_W-1:0];

    always_comb begin
        low_e_eval = low_e_q;
        if (bus.energy < bus.e_threshold) begin
            low_e_eval = 1'b1;
        end else if (bus.energy >= rel_thr) begin
            low_e_eval = 1'b0;
        end
    end
`else
    logic unused_hyst;
    assign unused_hyst = ^HYST;
    assign low_e_eval  = (bus.energy < bus.e_threshold);
`endif

    // One restoring-division step: shift in the next dividend bit, subtract if the divisor fits.
    assign rem_shift = {rem_q, quo_q[WORD_W-1]};
    assign rem_sub   = rem_shift - {1'b0, dvs_q};
    assign step_fits = ~rem_sub[WORD_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        hops_d    = hops_q;
        qval_d    = qval_q;
        tslot_d   = tslot_q;
        role_d    = role_q;
        low_e_d   = low_e_q;
        hb_lock_d = hb_lock_q;
        q_vld_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.fPktType)
                        PKT_HB: begin
                            // Only the first HB of a round counts; DATA re-arms the lock.
                            if (!hb_lock_q) begin
                                hops_d    = hops_eff;
                                role_d    = 1'b0;
                                low_e_d   = low_e_eval;
                                hb_lock_d = 1'b1;
                                quo_d     = bus.energy;
                                rem_d     = '0;
                                dvs_d     = hops_eff;
                                cnt_d     = '0;
                                state_d   = ST_DIV;
                            end
                        end
                        PKT_CHE: begin
                            if (bus.destinationID == NODE_ID) begin
                                role_d = 1'b1;
                            end
                        end
                        PKT_INV: begin
                        end
                        PKT_CHTS: begin
                            if (!role_q && (bus.destinationID == NODE_ID)) begin
                                tslot_d = bus.timeslot;
                            end
                        end
                        PKT_DATA: begin
                            hb_lock_d = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_DIV: begin
                rem_d = step_fits ? rem_sub[WORD_W-1:0] : rem_shift[WORD_W-1:0];
                quo_d = {quo_q[WORD_W-2:0], step_fits};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                qval_d  = quo_q;
                q_vld_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            hops_q    <= '0;
            qval_q    <= '0;
            tslot_q   <= '0;
            role_q    <= 1'b0;
            low_e_q   <= 1'b0;
            hb_lock_q <= 1'b0;
            q_vld_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            hops_q    <= hops_d;
            qval_q    <= qval_d;
            tslot_q   <= tslot_d;
            role_q    <= role_d;
            low_e_q   <= low_e_d;
            hb_lock_q <= hb_lock_d;
            q_vld_q   <= q_vld_d;
        end
    end

    assign bus.myNodeID     = NODE_ID;
    assign bus.hopsFromSink = hops_q;
    assign bus.myQValue     = qval_q;
    assign bus.myTimeslot   = tslot_q;
    assign bus.role         = role_q;
    assign bus.low_E        = low_e_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.q_valid      = q_vld_q;

endmodule

// File: tb/tb_node_info_ctrl.sv
// Directed bench for node_info_ctrl: packet decoding, HB lock, divider timing/result, async reset mid-divide.
// Expected values are hand-computed; low-energy expectations follow NODE_INFO_LOWE_HYST_EN when defined.
module tb_node_info_ctrl;

    localparam int          WORD_W  = 16;
    localparam logic [15:0] NODE_ID = 16'h000C;
    localparam logic [15:0] HYST    = 16'h0200;

    localparam logic [2:0] HB   = 3'b000;
    localparam logic [2:0] CHE  = 3'b001;
    localparam logic [2:0] INV  = 3'b010;
    localparam logic [2:0] CHTS = 3'b100;
    localparam logic [2:0] DATA = 3'b101;

    logic clk;
    logic nrst;
    int   tests;
    int   fails;
    int   nbusy;
    int   nq;
    int   qidx;

    node_info_ctrl_if #(.WORD_W(WORD_W)) bus ();

    node_info_ctrl #(
        .WORD_W  (WORD_W),
        .NODE_ID (NODE_ID),
        .HYST    (HYST)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one strobe cycle and returns at the following negedge.
    task automatic strobe(input logic [2:0] t, input logic [15:0] e, input logic [15:0] d,
                          input logic [15:0] h, input logic [15:0] ts);
        bus.fPktType      = t;
        bus.energy        = e;
        bus.destinationID = d;
        bus.hops          = h;
        bus.timeslot      = ts;
        bus.en_MNI        = 1'b1;
        @(negedge clk);
        bus.en_MNI        = 1'b0;
    endtask

    // Sample index 0 is the cycle right after the accepting edge.
    task automatic watch(input bit inject, output int n_busy, output int n_q, output int q_at);
        n_busy = 0;
        n_q    = 0;
        q_at   = -1;
        for (int i = 0; i < 25; i++) begin
            if (inject && i == 3) begin
                bus.fPktType      = CHE;
                bus.destinationID = NODE_ID;
                bus.en_MNI        = 1'b1;
            end
            if (i == 4) bus.en_MNI = 1'b0;
            if (bus.busy) n_busy++;
            if (bus.q_valid) begin
                n_q++;
                if (q_at < 0) q_at = i;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nrst  = 1'b0;
        bus.en_MNI        = 1'b0;
        bus.fPktType      = 3'b000;
        bus.energy        = '0;
        bus.destinationID = '0;
        bus.hops          = '0;
        bus.timeslot      = '0;
        bus.e_threshold   = 16'h3333;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        check("rst_node_id", 32'(bus.myNodeID), 32'h000C);
        check("rst_hops",    32'(bus.hopsFromSink), 32'h0);
        check("rst_qval",    32'(bus.myQValue), 32'h0);
        check("rst_tslot",   32'(bus.myTimeslot), 32'h0);
        check("rst_role",    32'(bus.role), 32'h0);
        check("rst_low_e",   32'(bus.low_E), 32'h0);
        check("rst_busy",    32'(bus.busy), 32'h0);
        check("rst_q_valid", 32'(bus.q_valid), 32'h0);

        // First HB: 0x8000 / 1, with a CHE to this node injected while busy (must be dropped).
        strobe(HB, 16'h8000, 16'h0, 16'd1, 16'h0);
        check("hb1_hops",  32'(bus.hopsFromSink), 32'd1);
        check("hb1_low_e", 32'(bus.low_E), 32'h0);
        check("hb1_busy0", 32'(bus.busy), 32'h1);
        watch(1'b1, nbusy, nq, qidx);
        check("hb1_busy_cycles", 32'(nbusy), 32'd17);
        check("hb1_q_pulses",    32'(nq), 32'd1);
        check("hb1_q_index",     32'(qidx), 32'd17);
        check("hb1_qval",        32'(bus.myQValue), 32'h8000);
        check("hb1_busy_drop",   32'(bus.role), 32'h0);

        // Locked HB is dropped entirely.
        strobe(HB, 16'h7FC0, 16'h0, 16'd2, 16'h0);
        check("hb_lock_busy", 32'(bus.busy), 32'h0);
        check("hb_lock_hops", 32'(bus.hopsFromSink), 32'd1);
        repeat (20) @(negedge clk);
        check("hb_lock_qval", 32'(bus.myQValue), 32'h8000);

        strobe(CHE, 16'h0, 16'd32, 16'h0, 16'h0);
        check("che_other_role", 32'(bus.role), 32'h0);
        strobe(INV, 16'h0, NODE_ID, 16'd9, 16'd9);
        check("inv_role", 32'(bus.role), 32'h0);
        check("inv_hops", 32'(bus.hopsFromSink), 32'd1);
        strobe(CHE, 16'h0, NODE_ID, 16'h0, 16'h0);
        check("che_mine_role", 32'(bus.role), 32'h1);
        strobe(CHTS, 16'h0, NODE_ID, 16'd7, 16'd4);
        check("chts_as_ch", 32'(bus.myTimeslot), 32'h0);

        // New round: 0x6000 / 3 = 0x2000.
        strobe(DATA, 16'h0, 16'h0, 16'h0, 16'h0);
        strobe(HB, 16'h6000, 16'h0, 16'd3, 16'h0);
        check("hb3_role", 32'(bus.role), 32'h0);
        check("hb3_hops", 32'(bus.hopsFromSink), 32'd3);
        watch(1'b0, nbusy, nq, qidx);
        check("hb3_qval", 32'(bus.myQValue), 32'h2000);
        check("hb3_q_pulses", 32'(nq), 32'd1);
        strobe(CHTS, 16'h0, NODE_ID, 16'd7, 16'd5);
        check("chts_member", 32'(bus.myTimeslot), 32'd5);
        check("chts_hops_kept", 32'(bus.hopsFromSink), 32'd3);

        // Remainder discarded: 0x7FFF / 3 = 0x2AAA.
        strobe(DATA, 16'h0, 16'h0, 16'h0, 16'h0);
        strobe(HB, 16'h7FFF, 16'h0, 16'd3, 16'h0);
        watch(1'b0, nbusy, nq, qidx);
        check("hb_rem_qval", 32'(bus.myQValue), 32'h2AAA);

        // hops = 0 coerced to 1; energy below threshold.
        strobe(DATA, 16'h0, 16'h0, 16'h0, 16'h0);
        strobe(HB, 16'h3000, 16'h0, 16'd0, 16'h0);
        check("hb0_hops",  32'(bus.hopsFromSink), 32'd1);
        check("hb0_low_e", 32'(bus.low_E), 32'h1);
        watch(1'b0, nbusy, nq, qidx);
        check("hb0_qval", 32'(bus.myQValue), 32'h3000);

        // Energy between threshold and threshold+HYST, then above it.
        strobe(DATA, 16'h0, 16'h0, 16'h0, 16'h0);
        strobe(HB, 16'h3400, 16'h0, 16'd1, 16'h0);
`ifdef NODE_INFO_LOWE_HYST_EN
        check("hyst_hold", 32'(bus.low_E), 32'h1);
`else
        check("hyst_hold", 32'(bus.low_E), 32'h0);
`endif
        watch(1'b0, nbusy, nq, qidx);
        strobe(DATA, 16'h0, 16'h0, 16'h0, 16'h0);
        strobe(HB, 16'h3000, 16'h0, 16'd1, 16'h0);
        watch(1'b0, nbusy, nq, qidx);
        strobe(DATA, 16'h0, 16'h0, 16'h0, 16'h0);
        strobe(HB, 16'h3600, 16'h0, 16'd1, 16'h0);
        check("hyst_release", 32'(bus.low_E), 32'h0);
        watch(1'b0, nbusy, nq, qidx);

        // Reset mid-divide: everything back to reset values, no late q_valid.
        strobe(DATA, 16'h0, 16'h0, 16'h0, 16'h0);
        strobe(HB, 16'h2000, 16'h0, 16'd5, 16'h0);
        check("pre_rst_low_e", 32'(bus.low_E), 32'h1);
        repeat (5) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("mid_rst_busy",  32'(bus.busy), 32'h0);
        check("mid_rst_hops",  32'(bus.hopsFromSink), 32'h0);
        check("mid_rst_qval",  32'(bus.myQValue), 32'h0);
        check("mid_rst_tslot", 32'(bus.myTimeslot), 32'h0);
        check("mid_rst_low_e", 32'(bus.low_E), 32'h0);
        check("mid_rst_role",  32'(bus.role), 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        watch(1'b0, nbusy, nq, qidx);
        check("post_rst_no_q", 32'(nq), 32'd0);
        check("post_rst_qval", 32'(bus.myQValue), 32'h0);

        // Reset cleared the HB lock: 0x4000 / 2 = 0x2000 without a DATA first.
        strobe(HB, 16'h4000, 16'h0, 16'd2, 16'h0);
        check("post_rst_hops", 32'(bus.hopsFromSink), 32'd2);
        watch(1'b0, nbusy, nq, qidx);
        check("post_rst_hb_qval", 32'(bus.myQValue), 32'h2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
